// File: rtl/clk_divider_multi.sv
// ---------------------------------------------------------------------------
// clk_divider_multi
//   Multi-channel programmable clock divider. Every channel produces a 50 %
//   duty divided clock and a one-cycle tick on each of its rising edges. Each
//   channel's half-period HP can be changed at runtime. Output period is
//   2*(HP+1) clk_in cycles.
//
//   A new HP is first stored in a shadow register. It moves into the active
//   register at the next falling edge of that channel, so a change never
//   produces a runt pulse. It also moves in straight away while the channel
//   is disabled or being restarted.
//
//   Optional build macro: CLKDIV_SYNC_EN
//     When defined, the block gains a 'sync' input. Pulsing sync restarts
//     every enabled channel at phase zero, so all channels become aligned.
//
// Ports
//   clk_in       input clock
//   reset        synchronous, active-high reset
//   ch_en        per-channel run enable
//   div_wr       write strobe for a new half-period value
//   div_ch       target channel of the write; out-of-range writes are ignored
//   div_val      new half-period value HP
//   sync         (CLKDIV_SYNC_EN only) phase-align restart of enabled channels
//   clk_out      divided clocks
//   tick         one-cycle pulse registered together with each rising clk_out
//   div_pending  shadow HP written but not yet applied
// ---------------------------------------------------------------------------

// One divider channel: counter, active and shadow half-period, output flops.
module clk_divider_ch #(
    parameter int               CNT_W  = 27,
    parameter logic [CNT_W-1:0] HP_DEF = '0
) (
    input  logic             clk_in,
    input  logic             reset,
    input  logic             en,
`ifdef CLKDIV_SYNC_EN
    input  logic             sync,
`endif
    input  logic             wr,
    input  logic [CNT_W-1:0] val,
    output logic             clk_out,
    output logic             tick,
    output logic             pending
);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] hp_act;
    logic [CNT_W-1:0] hp_shd;
    logic             restart;
    logic             at_end;
    logic             boundary;
    logic             apply;

    // A disabled channel, or a sync pulse, parks the channel at phase zero.
`ifdef CLKDIV_SYNC_EN
    assign restart  = ~en | sync;
`else
    assign restart  = ~en;
`endif
    assign at_end   = (cnt == hp_act);
    // The period boundary is the 1->0 toggle. Only here, or while the channel
    // is parked, is cnt guaranteed to restart at 0. So HP may change safely
    // only at these points.
    assign boundary = at_end & clk_out;
    assign apply    = restart | boundary;

    always_ff @(posedge clk_in) begin
        if (reset) begin
            cnt     <= '0;
            hp_act  <= HP_DEF;
            hp_shd  <= HP_DEF;
            pending <= 1'b0;
            clk_out <= 1'b0;
            tick    <= 1'b0;
        end else begin
            // Half-period bookkeeping. A write that coincides with an apply
            // point goes straight into the active register.
            if (apply) begin
                if (wr) begin
                    hp_act  <= val;
                    hp_shd  <= val;
                    pending <= 1'b0;
                end else if (pending) begin
                    hp_act  <= hp_shd;
                    pending <= 1'b0;
                end
            end else if (wr) begin
                hp_shd  <= val;
                pending <= 1'b1;
            end

            // Counter and output waveform.
            if (restart) begin
                cnt     <= '0;
                clk_out <= 1'b0;
                tick    <= 1'b0;
            end else if (at_end) begin
                cnt     <= '0;
                clk_out <= ~clk_out;
                tick    <= ~clk_out;
            end else begin
                cnt     <= cnt + CNT_W'(1);
                tick    <= 1'b0;
            end
        end
    end

endmodule

module clk_divider_multi #(
    parameter int IN_CLK_FREQ  = 100_000_000,
    parameter int N_CH         = 4,
    parameter int DEFAULT_FREQ = 1,
    parameter int CNT_W        = 27,
    parameter int CH_W         = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic             clk_in,
    input  logic             reset,
    input  logic [N_CH-1:0]  ch_en,
    input  logic             div_wr,
    input  logic [CH_W-1:0]  div_ch,
    input  logic [CNT_W-1:0] div_val,
`ifdef CLKDIV_SYNC_EN
    input  logic             sync,
`endif
    output logic [N_CH-1:0]  clk_out,
    output logic [N_CH-1:0]  tick,
    output logic [N_CH-1:0]  div_pending
);

    localparam logic [CNT_W-1:0] HP_DEF = CNT_W'(IN_CLK_FREQ / (2 * DEFAULT_FREQ) - 1);

    logic [N_CH-1:0] wr_hit;

    // Decode the write. A channel index outside 0..N_CH-1 never matches any
    // lane, so such a write is dropped without touching any state.
    always_comb begin
        wr_hit = '0;
        for (int i = 0; i < N_CH; i++) begin
            wr_hit[i] = div_wr && (32'(div_ch) == i);
        end
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        clk_divider_ch #(
            .CNT_W  (CNT_W),
            .HP_DEF (HP_DEF)
        ) u_ch (
            .clk_in  (clk_in),
            .reset   (reset),
            .en      (ch_en[i]),
`ifdef CLKDIV_SYNC_EN
            .sync    (sync),
`endif
            .wr      (wr_hit[i]),
            .val     (div_val),
            .clk_out (clk_out[i]),
            .tick    (tick[i]),
            .pending (div_pending[i])
        );
    end

endmodule

// File: tb/tb_clk_divider_multi.sv
// ---------------------------------------------------------------------------
// tb_clk_divider_multi
//   Self-checking bench for clk_divider_multi. It uses IN_CLK_FREQ=1000 and
//   DEFAULT_FREQ=100, which gives HP=4. It uses three channels so that
//   div_ch=3 is an out-of-range index. The reference model tracks, for each
//   channel, the absolute cycle of its next toggle, the output level, and the
//   active, shadow and pending half-period state. The model is stepped once
//   per clock edge and compared against every output on every cycle.
// ---------------------------------------------------------------------------
module tb_clk_divider_multi;

    localparam int N   = 3;
    localparam int CW  = 8;
    localparam int HPD = 4;

    logic          clk_in = 1'b0;
    logic          reset  = 1'b1;
    logic [N-1:0]  ch_en  = '0;
    logic          div_wr = 1'b0;
    logic [1:0]    div_ch = '0;
    logic [CW-1:0] div_val = '0;
    logic          sync   = 1'b0;
    logic [N-1:0]  clk_out;
    logic [N-1:0]  tick;
    logic [N-1:0]  div_pending;

    clk_divider_multi #(
        .IN_CLK_FREQ  (1000),
        .N_CH         (N),
        .DEFAULT_FREQ (100),
        .CNT_W        (CW)
    ) dut (
        .clk_in      (clk_in),
        .reset       (reset),
        .ch_en       (ch_en),
        .div_wr      (div_wr),
        .div_ch      (div_ch),
        .div_val     (div_val),
`ifdef CLKDIV_SYNC_EN
        .sync        (sync),
`endif
        .clk_out     (clk_out),
        .tick        (tick),
        .div_pending (div_pending)
    );

    always #5 clk_in = ~clk_in;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model state.
    longint cyc = 0;
    longint m_nxt [N];
    int     m_lvl [N];
    int     m_tk  [N];
    int     m_pend[N];
    int     m_act [N];
    int     m_shd [N];

    task automatic model_edge();
        bit sy, hit, restart, fall;
`ifdef CLKDIV_SYNC_EN
        sy = sync;
`else
        sy = 1'b0;
`endif
        for (int i = 0; i < N; i++) begin
            if (reset) begin
                m_lvl[i] = 0; m_tk[i] = 0; m_pend[i] = 0;
                m_act[i] = HPD; m_shd[i] = HPD;
                m_nxt[i] = cyc + HPD + 1;
            end else begin
                hit     = div_wr && (int'(div_ch) == i);
                restart = !ch_en[i] || sy;
                fall    = !restart && (cyc == m_nxt[i]) && (m_lvl[i] == 1);
                if (restart || fall) begin
                    if (hit) begin
                        m_act[i] = int'(div_val); m_shd[i] = int'(div_val); m_pend[i] = 0;
                    end else if (m_pend[i] != 0) begin
                        m_act[i] = m_shd[i]; m_pend[i] = 0;
                    end
                end else if (hit) begin
                    m_shd[i] = int'(div_val); m_pend[i] = 1;
                end
                if (restart) begin
                    m_lvl[i] = 0; m_tk[i] = 0;
                    m_nxt[i] = cyc + m_act[i] + 1;
                end else if (cyc == m_nxt[i]) begin
                    m_lvl[i] = 1 - m_lvl[i];
                    m_tk[i]  = m_lvl[i];
                    m_nxt[i] = cyc + m_act[i] + 1;
                end else begin
                    m_tk[i] = 0;
                end
            end
        end
    endtask

    task automatic step();
        @(posedge clk_in);
        model_edge();
        cyc++;
        #1;
        for (int i = 0; i < N; i++) begin
            chk($sformatf("clk_out[%0d]", i), 32'(clk_out[i]), m_lvl[i]);
            chk($sformatf("tick[%0d]", i), 32'(tick[i]), m_tk[i]);
            chk($sformatf("div_pending[%0d]", i), 32'(div_pending[i]), m_pend[i]);
        end
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    // Advance until channel ch is high and its next edge is NOT the fall.
    // When last is set, advance until the next edge IS the fall instead.
    task automatic wait_high(input int ch, input bit last, input string tag);
        int  k;
        bit  ok;
        ok = 1'b0;
        for (k = 0; k < 60; k++) begin
            if (m_lvl[ch] == 1 && (last ? (m_nxt[ch] == cyc) : (m_nxt[ch] > cyc))) begin
                ok = 1'b1;
                break;
            end
            step();
        end
        chk(tag, 32'(ok), 1);
    endtask

    task automatic write(input int ch, input int val);
        div_wr = 1'b1; div_ch = 2'(ch); div_val = CW'(val);
        step();
        div_wr = 1'b0;
    endtask

    initial begin
        // Reset state.
        run(3);
        chk("rst_clk_out", 32'(clk_out), 0);
        chk("rst_tick", 32'(tick), 0);
        chk("rst_pending", 32'(div_pending), 0);
        reset = 1'b0;

        // Default waveform: period 10.
        ch_en = '1;
        run(35);

        // Mid-high write to ch0: pending until the fall, then period 4.
        wait_high(0, 1'b0, "wait_ch0_high");
        write(0, 1);
        chk("pend_after_wr", 32'(div_pending[0]), 1);
        run(30);

        // Write exactly at the ch0 boundary: applied immediately, max rate.
        wait_high(0, 1'b1, "wait_ch0_fall");
        write(0, 0);
        chk("boundary_no_pend", 32'(div_pending[0]), 0);
        run(12);

        // Out-of-range channel write is ignored.
        write(3, 7);
        chk("oor_no_pend", 32'(div_pending), 0);
        run(12);

        // Disable ch1 mid-high with a pending shadow, then re-enable it.
        wait_high(1, 1'b0, "wait_ch1_high");
        write(1, 2);
        ch_en[1] = 1'b0;
        step();
        chk("dis_clk_low", 32'(clk_out[1]), 0);
        chk("dis_applied", 32'(div_pending[1]), 0);
        run(4);
        ch_en[1] = 1'b1;
        run(25);

        // Reset while ch2 is high with a pending write.
        wait_high(2, 1'b0, "wait_ch2_high");
        write(2, 6);
        chk("pre_rst_pend", 32'(div_pending[2]), 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("mid_rst_out", 32'(clk_out), 0);
        chk("mid_rst_pend", 32'(div_pending), 0);
        run(25);

`ifdef CLKDIV_SYNC_EN
        // Put ch1 out of phase, then realign every channel with sync.
        ch_en[1] = 1'b0;
        run(3);
        ch_en[1] = 1'b1;
        run(7);
        sync = 1'b1;
        step();
        sync = 1'b0;
        chk("sync_low", 32'(clk_out), 0);
        for (int k = 0; k < 20; k++) begin
            step();
            chk("sync_aligned", 32'(clk_out[1]), 32'(clk_out[0]));
        end
`endif

        // Randomized traffic.
        for (int k = 0; k < 2500; k++) begin
            for (int i = 0; i < N; i++) ch_en[i] = ($urandom_range(0, 19) != 0);
            div_wr  = ($urandom_range(0, 7) == 0);
            div_ch  = 2'($urandom_range(0, 3));
            div_val = CW'($urandom_range(0, 6));
`ifdef CLKDIV_SYNC_EN
            sync    = ($urandom_range(0, 99) == 0);
`endif
            reset   = ($urandom_range(0, 499) == 0);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
